// File: rtl/register_mode_cfg.sv
// register_mode_cfg: config front-end for RegisterMode (mode/const_ regs, preload pulse, clk_en stall); readback path enabled by REGISTER_MODE_CFG_READBACK_EN
module register_mode_cfg #(
  parameter int WIDTH  = 4,
  parameter int MODE_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              ASYNCRESETN,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_write,
  input  logic [1:0]        cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [CNT_W-1:0]  rd_data,
  input  logic [WIDTH-1:0]  reg_value,
  output logic [MODE_W-1:0] mode,
  output logic [WIDTH-1:0]  const_,
  output logic              config_we,
  output logic [WIDTH-1:0]  config_data,
  output logic              clk_en
);
  logic             accept;
  logic             wrAccept;
  logic [CNT_W-1:0] stallCnt;
  assign accept   = cfg_valid && cfg_ready;
  assign wrAccept = accept && cfg_write;
  // clk_en comes straight from the counter register so cfg_* never reaches it combinationally
  assign clk_en   = stallCnt == '0;
  // mode and const_ registers; a write of the reserved mode value 3 is dropped
  always_ff @(posedge CLK or negedge ASYNCRESETN)
    if (!ASYNCRESETN) begin
      mode   <= '0;
      const_ <= '0;
    end else begin
      if (wrAccept && cfg_addr == 2'd0 && cfg_wdata[1:0] != 2'd3) mode <= MODE_W'(cfg_wdata[1:0]);
      if (wrAccept && cfg_addr == 2'd1) const_ <= cfg_wdata[WIDTH-1:0];
    end
  // preload: one-cycle config_we pulse per accepted write, data held afterwards
  always_ff @(posedge CLK or negedge ASYNCRESETN)
    if (!ASYNCRESETN) begin
      config_we   <= 1'b0;
      config_data <= '0;
    end else begin
      config_we <= wrAccept && cfg_addr == 2'd2;
      if (wrAccept && cfg_addr == 2'd2) config_data <= cfg_wdata[WIDTH-1:0];
    end
  // stall counter: load on write, otherwise count down to zero and stay there
  always_ff @(posedge CLK or negedge ASYNCRESETN)
    if (!ASYNCRESETN) stallCnt <= '0;
    else if (wrAccept && cfg_addr == 2'd3) stallCnt <= cfg_wdata;
    else if (stallCnt != '0) stallCnt <= stallCnt - CNT_W'(1);
`ifdef REGISTER_MODE_CFG_READBACK_EN
  typedef enum logic {IDLE, RESP} state_t;
  state_t           state;
  state_t           nextState;
  logic [CNT_W-1:0] readMux;
  assign readMux = cfg_addr == 2'd0 ? CNT_W'(mode) :
                   cfg_addr == 2'd1 ? CNT_W'(const_) :
                   cfg_addr == 2'd2 ? CNT_W'(reg_value) : stallCnt;
  // state register
  always_ff @(posedge CLK or negedge ASYNCRESETN)
    if (!ASYNCRESETN) state <= IDLE;
    else state <= nextState;
  // next state: reads park in RESP until the response is taken
  always_comb
    nextState = state == IDLE ? ((accept && !cfg_write) ? RESP : IDLE) : (rd_ready ? IDLE : RESP);
  // handshake outputs decoded from state
  always_comb begin
    cfg_ready = state == IDLE;
    rd_valid  = state == RESP;
  end
  // response data captured at the read accept edge and held through RESP
  always_ff @(posedge CLK or negedge ASYNCRESETN)
    if (!ASYNCRESETN) rd_data <= '0;
    else if (accept && !cfg_write) rd_data <= readMux;
`else
  logic unusedRead;
  assign unusedRead = ^{rd_ready, reg_value};
  assign cfg_ready  = 1'b1;
  assign rd_valid   = 1'b0;
  assign rd_data    = '0;
`endif
endmodule

// File: tb/tb_register_mode_cfg.sv
// tb_register_mode_cfg: directed self-checking bench for register_mode_cfg
module tb_register_mode_cfg;
  logic       CLK = 1'b0;
  logic       ASYNCRESETN = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic       cfg_write = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_wdata = 8'd0;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic [3:0] reg_value = 4'd0;
  logic [1:0] mode;
  logic [3:0] const_;
  logic       config_we;
  logic [3:0] config_data;
  logic       clk_en;
  int total = 0;
  int passed = 0;

  register_mode_cfg #(.WIDTH(4), .MODE_W(2), .CNT_W(8)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_write(cfg_write),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .reg_value(reg_value), .mode(mode), .const_(const_),
    .config_we(config_we), .config_data(config_data), .clk_en(clk_en)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_write = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (mode !== 2'd0) $display("FAIL reset_mode: got %0h want 0", mode); else passed++;
    total++; if (const_ !== 4'd0) $display("FAIL reset_const: got %0h want 0", const_); else passed++;
    total++; if (config_we !== 1'b0) $display("FAIL reset_we: got %0b want 0", config_we); else passed++;
    total++; if (config_data !== 4'd0) $display("FAIL reset_cdata: got %0h want 0", config_data); else passed++;
    total++; if (clk_en !== 1'b1) $display("FAIL reset_clk_en: got %0b want 1", clk_en); else passed++;
    total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); else passed++;
    total++; if (rd_data !== 8'd0) $display("FAIL reset_rd_data: got %0h want 0", rd_data); else passed++;
    total++; if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %0b want 1", cfg_ready); else passed++;
    ASYNCRESETN = 1'b1;
    tick();
  endtask

  task automatic test_mode_const();
    do_write(2'd0, 8'h02);
    total++; if (mode !== 2'd2) $display("FAIL mode_write: got %0h want 2", mode); else passed++;
    do_write(2'd1, 8'hFA);
    total++; if (const_ !== 4'hA) $display("FAIL const_write: got %0h want a", const_); else passed++;
    do_write(2'd0, 8'h03);
    total++; if (mode !== 2'd2) $display("FAIL mode_reserved: got %0h want 2", mode); else passed++;
  endtask

  task automatic test_preload();
    cfg_valid = 1'b1; cfg_write = 1'b1; cfg_addr = 2'd2; cfg_wdata = 8'h05;
    tick();
    cfg_wdata = 8'h09;
    total++; if (config_we !== 1'b1) $display("FAIL preload1_we: got %0b want 1", config_we); else passed++;
    total++; if (config_data !== 4'h5) $display("FAIL preload1_data: got %0h want 5", config_data); else passed++;
    tick();
    cfg_valid = 1'b0;
    total++; if (config_we !== 1'b1) $display("FAIL preload2_we: got %0b want 1", config_we); else passed++;
    total++; if (config_data !== 4'h9) $display("FAIL preload2_data: got %0h want 9", config_data); else passed++;
    tick();
    total++; if (config_we !== 1'b0) $display("FAIL preload_end_we: got %0b want 0", config_we); else passed++;
    total++; if (config_data !== 4'h9) $display("FAIL preload_hold: got %0h want 9", config_data); else passed++;
  endtask

  task automatic test_stall();
    int n;
    do_write(2'd3, 8'd3);
    n = 0;
    for (int i = 0; i < 20 && clk_en === 1'b0; i++) begin n++; tick(); end
    total++; if (n != 3) $display("FAIL stall3_len: got %0d want 3", n); else passed++;
    do_write(2'd3, 8'd3);
    tick();
    tick();
    do_write(2'd3, 8'd5);
    n = 0;
    for (int i = 0; i < 20 && clk_en === 1'b0; i++) begin n++; tick(); end
    total++; if (n != 5) $display("FAIL stall_reload_len: got %0d want 5", n); else passed++;
    do_write(2'd3, 8'd5);
    tick();
    total++; if (clk_en !== 1'b0) $display("FAIL stall_mid: got %0b want 0", clk_en); else passed++;
    do_write(2'd3, 8'd0);
    total++; if (clk_en !== 1'b1) $display("FAIL stall_cancel: got %0b want 1", clk_en); else passed++;
  endtask

`ifdef REGISTER_MODE_CFG_READBACK_EN
  task automatic test_readback();
    reg_value = 4'hC;
    cfg_valid = 1'b1; cfg_write = 1'b0; cfg_addr = 2'd2;
    tick();
    cfg_valid = 1'b0;
    reg_value = 4'h3;
    for (int i = 0; i < 4; i++) begin
      total++; if (rd_valid !== 1'b1) $display("FAIL resp_valid%0d: got %0b want 1", i, rd_valid); else passed++;
      total++; if (rd_data !== 8'h0C) $display("FAIL resp_data%0d: got %0h want 0c", i, rd_data); else passed++;
      total++; if (cfg_ready !== 1'b0) $display("FAIL resp_ready%0d: got %0b want 0", i, cfg_ready); else passed++;
      tick();
    end
    cfg_valid = 1'b1; cfg_write = 1'b1; cfg_addr = 2'd0; cfg_wdata = 8'h01;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    total++; if (rd_valid !== 1'b0) $display("FAIL resp_done: got %0b want 0", rd_valid); else passed++;
    total++; if (mode !== 2'd2) $display("FAIL queued_not_yet: got %0h want 2", mode); else passed++;
    tick();
    cfg_valid = 1'b0;
    total++; if (mode !== 2'd1) $display("FAIL queued_write: got %0h want 1", mode); else passed++;
    cfg_valid = 1'b1; cfg_write = 1'b0; cfg_addr = 2'd1;
    tick();
    cfg_valid = 1'b0;
    total++; if (rd_data !== 8'h0A) $display("FAIL read_const: got %0h want 0a", rd_data); else passed++;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    total++; if (cfg_ready !== 1'b1) $display("FAIL read_const_idle: got %0b want 1", cfg_ready); else passed++;
  endtask
`else
  task automatic test_no_readback();
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1; cfg_write = 1'b0; cfg_addr = 2'(i); cfg_wdata = 8'hFF;
      total++; if (cfg_ready !== 1'b1) $display("FAIL nrb_ready%0d: got %0b want 1", i, cfg_ready); else passed++;
      tick();
      cfg_valid = 1'b0;
      total++; if (rd_valid !== 1'b0) $display("FAIL nrb_valid%0d: got %0b want 0", i, rd_valid); else passed++;
      total++; if (rd_data !== 8'd0) $display("FAIL nrb_data%0d: got %0h want 0", i, rd_data); else passed++;
      total++; if (mode !== 2'd2 || const_ !== 4'hA) $display("FAIL nrb_regs%0d: got %0h/%0h want 2/a", i, mode, const_); else passed++;
    end
  endtask
`endif

  task automatic test_reset_midflight();
    do_write(2'd0, 8'h02);
    do_write(2'd3, 8'd50);
`ifdef REGISTER_MODE_CFG_READBACK_EN
    cfg_valid = 1'b1; cfg_write = 1'b0; cfg_addr = 2'd3;
    tick();
    cfg_valid = 1'b0;
    total++; if (rd_valid !== 1'b1) $display("FAIL pre_reset_resp: got %0b want 1", rd_valid); else passed++;
`endif
    total++; if (clk_en !== 1'b0) $display("FAIL pre_reset_stall: got %0b want 0", clk_en); else passed++;
    #2 ASYNCRESETN = 1'b0;
    #1;
    total++; if (rd_valid !== 1'b0) $display("FAIL rst_rd_valid: got %0b want 0", rd_valid); else passed++;
    total++; if (clk_en !== 1'b1) $display("FAIL rst_clk_en: got %0b want 1", clk_en); else passed++;
    total++; if (mode !== 2'd0) $display("FAIL rst_mode: got %0h want 0", mode); else passed++;
    total++; if (cfg_ready !== 1'b1) $display("FAIL rst_cfg_ready: got %0b want 1", cfg_ready); else passed++;
    #1 ASYNCRESETN = 1'b1;
    tick();
    do_write(2'd2, 8'h07);
    total++; if (config_we !== 1'b1) $display("FAIL pulse_before_rst: got %0b want 1", config_we); else passed++;
    #2 ASYNCRESETN = 1'b0;
    #1;
    total++; if (config_we !== 1'b0) $display("FAIL rst_abort_we: got %0b want 0", config_we); else passed++;
    total++; if (config_data !== 4'd0) $display("FAIL rst_cdata: got %0h want 0", config_data); else passed++;
    #1 ASYNCRESETN = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_mode_const();
    test_preload();
    test_stall();
`ifdef REGISTER_MODE_CFG_READBACK_EN
    test_readback();
`else
    test_no_readback();
`endif
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/register_mode_cfg.md
Name: register_mode_cfg

Overview:
- Configuration front-end sitting directly upstream of the RegisterMode block.
- Accepts config reads and writes over a valid/ready request channel and holds the `mode` and `const_` registers.
- Generates the `config_we`/`config_data` preload pulse and the `clk_en` stall window that RegisterMode consumes.
- Returns readback data on a separate valid/ready response channel.

Parameters:
- WIDTH, 4, data width of const_/config_data/readback (matches RegisterMode value width)
- MODE_W, 2, width of mode field
- CNT_W, 8, width of the clk_en stall counter

Ports:
- CLK  in  1  clock, rising edge
- ASYNCRESETN  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  request valid
- cfg_ready  out  1  request ready
- cfg_write  in  1  1=write, 0=read
- cfg_addr  in  2  register address
- cfg_wdata  in  CNT_W  write data (low bits used per address)
- rd_valid  out  1  read response valid
- rd_ready  in  1  read response accept
- rd_data  out  CNT_W  read response data, zero-extended
- reg_value  in  WIDTH  RegisterMode register output (self_register_O), for readback
- mode  out  MODE_W  to RegisterMode.mode
- const_  out  WIDTH  to RegisterMode.const_
- config_we  out  1  to RegisterMode.config_we
- config_data  out  WIDTH  to RegisterMode.config_data
- clk_en  out  1  to RegisterMode.clk_en

Behaviour:
- Reset (ASYNCRESETN low, takes effect immediately):
  - mode=0, const_=0, config_we=0, config_data=0, clk_en=1.
  - Stall counter=0, rd_valid=0, rd_data=0, FSM=IDLE, cfg_ready=1.
- Address map:
  - 0=mode: write uses wdata[1:0]. Value 3 is reserved; a write of 3 is accepted and ignored.
  - 1=const_: write uses wdata[WIDTH-1:0].
  - 2=preload.
  - 3=stall counter.
- Handshake: a request is accepted on a rising edge with cfg_valid&&cfg_ready. Requesters hold cfg_addr/cfg_write/cfg_wdata stable while cfg_valid is high and not yet accepted.
- FSM:
  - IDLE (cfg_ready=1):
    - Accepted write completes in place; FSM stays in IDLE.
    - Accepted read captures rd_data at the accept edge and moves to RESP.
  - RESP (cfg_ready=0, rd_valid=1): rd_data is held stable. On rd_valid&&rd_ready, go to IDLE; rd_valid=0 the next cycle.
- Write latency: mode/const_ visible the cycle after accept.
- Preload (addr 2 write):
  - config_data<=wdata[WIDTH-1:0] at the accept edge.
  - config_we=1 for exactly the following cycle, then 0.
  - Back-to-back preloads produce back-to-back single-cycle pulses, each with its own data.
  - config_data holds its last value when config_we=0.
- Stall (addr 3 write):
  - Loads counter=wdata.
  - clk_en = (counter==0), registered-state derived with no combinational path from cfg_* inputs.
  - Counter decrements by 1 each cycle while nonzero and saturates at 0.
  - A write while nonzero reloads; a write of 0 cancels (clk_en=1 next cycle).
  - N>0 yields exactly N cycles of clk_en=0 starting the cycle after accept.
- Readback values (at the accept edge):
  - addr0: mode, zero-extended.
  - addr1: const_.
  - addr2: reg_value sampled at accept.
  - addr3: current counter value.
- No new request is accepted in RESP; cfg_valid may stay high and is accepted on the first IDLE cycle.
- Reset mid-RESP: the response is dropped and rd_valid goes 0 immediately. Reset during a stall forces clk_en=1 and aborts a pending config_we pulse.

Optional Feature:
- Macro REGISTER_MODE_CFG_READBACK_EN.
- Defined: reads behave as above.
- Undefined:
  - The RESP state is removed, and rd_valid and rd_data are tied 0.
  - Reads are accepted in one cycle and have no effect.
  - cfg_ready is constant 1 after reset.
  - rd_ready is ignored.

Test Plan:
- Reset release, then write addr0=2 and addr1=4'hA → mode=2 and const_=4'hA the cycle after each accept. Write addr0=3 → mode stays 2.
- Preload 4'h5 then 4'h9 on consecutive cycles → config_we high for 2 consecutive cycles with config_data 5 then 9, then config_we=0 and config_data holds 9.
- Write addr3=3 → clk_en=0 for exactly 3 cycles then 1. Rewrite addr3=5 at count 1 → 5 further low cycles. Write 0 mid-stall → clk_en=1 next cycle.
- Read addr2 with reg_value=4'hC, rd_ready held low 4 cycles → rd_valid high, rd_data=0x0C stable, cfg_ready=0 throughout. Assert rd_ready → back to IDLE. A queued write is then accepted.
- Assert ASYNCRESETN low mid-RESP and mid-stall → rd_valid=0, clk_en=1, mode=0 immediately without a clock edge.
- With REGISTER_MODE_CFG_READBACK_EN undefined: issue 3 reads → each accepted in 1 cycle, rd_valid never asserts, registers unchanged.
